// File: rtl/gray2bin_sched_if.sv
// gray2bin_sched_if
//   Bundles the request side and the result side of the shared Gray-to-binary
//   converter. The converter attaches through the slave modport. The
//   requesters and the consumer attach through the master modport.
//   Signals:
//     req_valid  NREQ       request pending, one bit per channel
//     req_gray   NREQ*SIZE  Gray code, channel k on bits [k*SIZE +: SIZE]
//     req_ready  NREQ       one-hot grant, combinational, only while idle
//     out_valid  1          result available
//     out_ready  1          consumer accepts the result
//     out_bin    SIZE       binary result
//     out_id     IDW        channel that produced out_bin
`timescale 1ns/1ps
interface gray2bin_sched_if #(
    parameter int SIZE = 10,
    parameter int NREQ = 4
);
    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [NREQ-1:0]      req_valid;
    logic [NREQ*SIZE-1:0] req_gray;
    logic [NREQ-1:0]      req_ready;
    logic                 out_valid;
    logic                 out_ready;
    logic [SIZE-1:0]      out_bin;
    logic [IDW-1:0]       out_id;

    modport slave (
        input  req_valid, req_gray, out_ready,
        output req_ready, out_valid, out_bin, out_id
    );

    modport master (
        output req_valid, req_gray, out_ready,
        input  req_ready, out_valid, out_bin, out_id
    );
endinterface

// File: rtl/gray2bin_sched.sv
// gray2bin_sched
//   One bit-serial Gray-to-binary converter shared by NREQ requesters.
//   A round-robin arbiter picks one pending request while idle. The code is
//   converted MSB-first at one bit per clock over SIZE cycles. The result is
//   then held on a valid/ready port until the consumer takes it.
//   Ports:
//     clk    rising-edge clock
//     rst_n  asynchronous active-low reset
//     bus    gray2bin_sched_if.slave (request and result handshakes)
//     busy   high whenever the FSM is not idle
`timescale 1ns/1ps
module gray2bin_sched #(
    parameter int SIZE = 10,
    parameter int NREQ = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    gray2bin_sched_if.slave   bus,
    output logic              busy
);
    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW  = $clog2(SIZE);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CONV = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    state_t          state_q;
    logic [IDW-1:0]  ptr_q;
    logic [IDW-1:0]  id_q;
    logic [SIZE-1:0] gsh_q;
    logic [SIZE-1:0] acc_q;
    logic            par_q;
    logic [CW-1:0]   cnt_q;
    logic            out_valid_q;
    logic [SIZE-1:0] out_bin_q;
    logic [IDW-1:0]  out_id_q;

    logic            gnt_found_d;
    logic [IDW-1:0]  gnt_idx_d;
    logic [NREQ-1:0] gnt_oh_d;
    logic            par_d;
    logic [IDW-1:0]  ptr_d;
    int              idx_v;

    // Round-robin search: first pending channel at or after ptr, wrapping modulo NREQ.
    always_comb begin
        gnt_found_d = 1'b0;
        gnt_idx_d   = '0;
        idx_v       = 0;
        for (int i = 0; i < NREQ; i++) begin
            idx_v = int'(ptr_q) + i;
            if (idx_v >= NREQ) begin
                idx_v = idx_v - NREQ;
            end else begin
                idx_v = idx_v;
            end
            if (!gnt_found_d && bus.req_valid[idx_v]) begin
                gnt_found_d = 1'b1;
                gnt_idx_d   = IDW'(idx_v);
            end else begin
                gnt_found_d = gnt_found_d;
            end
        end
    end

    // One-hot grant, offered only while idle and never while reset is asserted.
    always_comb begin
        gnt_oh_d = '0;
        if (rst_n && (state_q == ST_IDLE) && gnt_found_d) begin
            gnt_oh_d[gnt_idx_d] = 1'b1;
        end else begin
            gnt_oh_d = '0;
        end
    end

    // Serial step and the pointer value used after a completed handshake.
    always_comb begin
        par_d = par_q ^ gsh_q[cnt_q];
        if (id_q == IDW'(NREQ - 1)) begin
            ptr_d = '0;
        end else begin
            ptr_d = id_q + IDW'(1);
        end
    end

    // Arbiter / converter / output FSM with registered result port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            ptr_q       <= '0;
            id_q        <= '0;
            gsh_q       <= '0;
            acc_q       <= '0;
            par_q       <= 1'b0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_bin_q   <= '0;
            out_id_q    <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (gnt_found_d) begin
                        gsh_q   <= bus.req_gray[gnt_idx_d*SIZE +: SIZE];
                        id_q    <= gnt_idx_d;
                        par_q   <= 1'b0;
                        cnt_q   <= CW'(SIZE - 1);
                        state_q <= ST_CONV;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_CONV: begin
                    // Running parity of the bits above and including cnt gives bin[cnt].
                    acc_q[cnt_q] <= par_d;
                    par_q        <= par_d;
                    if (cnt_q == '0) begin
                        out_bin_q   <= {acc_q[SIZE-1:1], par_d};
                        out_id_q    <= id_q;
                        out_valid_q <= 1'b1;
                        state_q     <= ST_HOLD;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                ST_HOLD: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        ptr_q       <= ptr_d;
                        state_q     <= ST_IDLE;
                    end else begin
                        state_q <= ST_HOLD;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    state_q     <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready = gnt_oh_d;
    assign bus.out_valid = out_valid_q;
    assign bus.out_bin   = out_bin_q;
    assign bus.out_id    = out_id_q;
    assign busy          = (state_q != ST_IDLE);

endmodule

// File: tb/tb_gray2bin_sched.sv
// tb_gray2bin_sched
//   Self-checking bench for gray2bin_sched (SIZE=10, NREQ=4). Inputs change
//   just after the falling edge and outputs are sampled 1 ns later. Expected
//   results come from a reference model: round-robin choice from a bench-side
//   pointer, and out_bin[i] as the XOR of gray bits SIZE-1..i.
`timescale 1ns/1ps
module tb_gray2bin_sched;
    localparam int SIZE = 10;
    localparam int NREQ = 4;

    logic clk;
    logic rst_n;
    logic busy;

    gray2bin_sched_if #(.SIZE(SIZE), .NREQ(NREQ)) bus ();

    gray2bin_sched #(.SIZE(SIZE), .NREQ(NREQ)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus),
        .busy  (busy)
    );

    int              vectors;
    int              miscompares;
    int              exp_ptr;
    logic [SIZE-1:0] g_arr [NREQ];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        vectors++;
        if (obs !== exp_v) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp_v, $time);
        end
    endtask

    function automatic logic [SIZE-1:0] ref_g2b(input logic [SIZE-1:0] g);
        logic [SIZE-1:0] b;
        for (int i = 0; i < SIZE; i++) b[i] = ^(g >> i);
        return b;
    endfunction

    function automatic int exp_grant(input logic [NREQ-1:0] v, input int p);
        for (int i = 0; i < NREQ; i++) begin
            if (v[(p + i) % NREQ]) return (p + i) % NREQ;
        end
        return -1;
    endfunction

    task automatic drive_gray();
        for (int k = 0; k < NREQ; k++) bus.req_gray[k*SIZE +: SIZE] = g_arr[k];
    endtask

    // Starts and ends just after a falling edge with the DUT idle.
    task automatic serve(input logic [NREQ-1:0] v, input bit drop, input int hold,
                         output int gid, output logic [SIZE-1:0] obin);
        int              k;
        int              n;
        logic [SIZE-1:0] g_cap;
        logic [SIZE-1:0] eb;
        gid  = -1;
        obin = '0;
        bus.req_valid = v;
        drive_gray();
        bus.out_ready = (hold == 0);
        #1;
        k = exp_grant(v, exp_ptr);
        n = 0;
        while (bus.req_ready == '0 && n < 40) begin
            @(negedge clk); #1; n++;
        end
        if (bus.req_ready == '0) begin
            chk("grant_timeout", 32'(0), 32'(1));
            return;
        end
        chk("req_ready_grant", 32'(bus.req_ready), 32'(1) << k);
        chk("busy_idle", 32'(busy), 32'(0));
        g_cap = g_arr[k];
        gid   = k;
        @(negedge clk);
        // New code for the granted channel must not disturb the captured one.
        g_arr[k] = SIZE'($urandom);
        if (drop) bus.req_valid[k] = 1'b0;
        drive_gray();
        #1;
        chk("busy_conv", 32'(busy), 32'(1));
        chk("req_ready_conv", 32'(bus.req_ready), 32'(0));
        n = 1;
        while (!bus.out_valid && n < 40) begin
            @(negedge clk); #1; n++;
        end
        chk("latency", 32'(n), 32'(SIZE + 1));
        eb = ref_g2b(g_cap);
        chk("out_bin", 32'(bus.out_bin), 32'(eb));
        chk("out_id", 32'(bus.out_id), 32'(k));
        obin = bus.out_bin;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk); #1;
            chk("hold_valid", 32'(bus.out_valid), 32'(1));
            chk("hold_bin", 32'(bus.out_bin), 32'(eb));
            chk("hold_id", 32'(bus.out_id), 32'(k));
            chk("hold_req_ready", 32'(bus.req_ready), 32'(0));
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        #1;
        chk("accept_valid", 32'(bus.out_valid), 32'(0));
        chk("accept_idle", 32'(busy), 32'(0));
        chk("retain_bin", 32'(bus.out_bin), 32'(eb));
        exp_ptr = (k + 1) % NREQ;
    endtask

    initial begin
        int              gid;
        logic [SIZE-1:0] obin;
        int              ids [6];
        int              exp_ord [6];
        int              ch;
        exp_ord = '{0, 1, 2, 3, 0, 1};
        vectors = 0;
        miscompares = 0;
        exp_ptr = 0;
        for (int k = 0; k < NREQ; k++) g_arr[k] = '0;
        rst_n = 1'b0;
        bus.req_valid = '1;
        bus.out_ready = 1'b0;
        drive_gray();

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        chk("rst_req_ready", 32'(bus.req_ready), 32'(0));
        chk("rst_out_valid", 32'(bus.out_valid), 32'(0));
        chk("rst_out_bin", 32'(bus.out_bin), 32'(0));
        chk("rst_out_id", 32'(bus.out_id), 32'(0));
        chk("rst_busy", 32'(busy), 32'(0));
        bus.req_valid = '0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;

        // All channels requesting: rotation 0,1,2,3,0,1
        for (int k = 0; k < NREQ; k++) g_arr[k] = SIZE'($urandom);
        for (int i = 0; i < 6; i++) begin
            serve('1, 1'b0, int'($urandom_range(3, 0)), gid, obin);
            ids[i] = gid;
        end
        bus.req_valid = '0;
        for (int i = 0; i < 6; i++) chk("rr_order", 32'(ids[i]), 32'(exp_ord[i]));

        // ch0 gray 10'h200 with out_ready held high
        g_arr[0] = 10'h200;
        serve(4'b0001, 1'b1, 0, gid, obin);
        chk("t1_bin", 32'(obin), 32'h3FF);
        chk("t1_id", 32'(gid), 32'(0));

        // ch2 all-zero then all-one codes
        g_arr[2] = 10'h000;
        serve(4'b0100, 1'b1, 0, gid, obin);
        chk("t2a_bin", 32'(obin), 32'h000);
        g_arr[2] = 10'h3FF;
        serve(4'b0100, 1'b1, 0, gid, obin);
        chk("t2b_bin", 32'(obin), 32'h2AA);
        chk("t2b_id", 32'(gid), 32'(2));

        // Five-cycle back-pressure with another channel still pending
        g_arr[1] = SIZE'($urandom);
        g_arr[2] = SIZE'($urandom);
        serve(4'b0110, 1'b1, 5, gid, obin);
        bus.req_valid = '0;

        // Reset in the 4th CONV cycle discards the conversion and clears ptr
        g_arr[1] = 10'h200;
        serve(4'b0010, 1'b1, 0, gid, obin);
        g_arr[3] = SIZE'($urandom);
        bus.req_valid = 4'b1000;
        drive_gray();
        #1;
        chk("t5_grant", 32'(bus.req_ready), 32'h8);
        @(negedge clk);
        bus.req_valid = 4'b0000;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        bus.req_valid = 4'b1010;
        #1;
        chk("t5_out_valid", 32'(bus.out_valid), 32'(0));
        chk("t5_out_bin", 32'(bus.out_bin), 32'(0));
        chk("t5_out_id", 32'(bus.out_id), 32'(0));
        chk("t5_busy", 32'(busy), 32'(0));
        chk("t5_req_ready", 32'(bus.req_ready), 32'(0));
        @(negedge clk);
        rst_n = 1'b1;
        exp_ptr = 0;
        #1;
        chk("t5_no_result", 32'(bus.out_valid), 32'(0));
        serve(4'b1010, 1'b1, 0, gid, obin);
        chk("t5_after_rst_id", 32'(gid), 32'(1));
        bus.req_valid = '0;

        // Full sweep of 10-bit Gray codes on random channels
        for (int kk = 0; kk < 1024; kk++) begin
            ch = int'($urandom_range(NREQ - 1, 0));
            g_arr[ch] = SIZE'(kk ^ (kk >> 1));
            serve(NREQ'(1) << ch, 1'b1, 0, gid, obin);
            chk("sweep_bin", 32'(obin), 32'(kk));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
